// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Holds the FSM encoding and the bit-counter width helper.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry hold register with full flag, used to park the next word
// while the current word is still shifting out.
module piso_hold_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel word to bit-serial converter with valid/ready on both sides.
// A one-word hold buffer lets consecutive words stream with no gap bits.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int unsigned   CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shift_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             consume;
  logic             last_bit;
  logic             hold_load;
  logic             hold_unload;

  assign a_ready  = ~hold_full;
  assign accept   = a_valid & a_ready;
  assign consume  = sout_valid & sout_ready;
  assign last_bit = (cnt_q == LastCnt);

  // The hold slot only fills while a word is shifting and is not just finishing.
  assign hold_load   = (state_q == ST_SHIFT) & accept & ~(consume & last_bit);
  assign hold_unload = (state_q == ST_SHIFT) & consume & last_bit & hold_full;

  always_comb begin
    shift_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_q <= a;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (consume) begin
            if (!last_bit) begin
              shreg_q <= shift_d;
              cnt_q   <= cnt_q + CntW'(1);
            end else if (hold_full) begin
              shreg_q <= hold_data;
              cnt_q   <= '0;
            end else if (accept) begin
              shreg_q <= a;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  piso_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .unload_i(hold_unload),
    .data_i  (a),
    .data_o  (hold_data),
    .full_o  (hold_full)
  );

  assign sout_valid = (state_q == ST_SHIFT);
  assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_first = sout_valid & (cnt_q == '0);
  assign sout_last  = sout_valid & last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: reset, framing, streaming,
// backpressure, mid-word reset and LSB-first ordering.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       a_valid;
  logic       a_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_ready;
  logic       sout_first;
  logic       sout_last;

  logic [3:0] a_l;
  logic       a_valid_l;
  logic       a_ready_l;
  logic       sout_l;
  logic       sout_valid_l;
  logic       sout_first_l;
  logic       sout_last_l;

  int n_checks = 0;
  int n_errors = 0;

  piso_serializer #(
    .WIDTH    (4),
    .MSB_FIRST(1'b1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_ready(sout_ready),
    .sout_first(sout_first),
    .sout_last (sout_last)
  );

  piso_serializer #(
    .WIDTH    (4),
    .MSB_FIRST(1'b0)
  ) u_dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .a         (a_l),
    .a_valid   (a_valid_l),
    .a_ready   (a_ready_l),
    .sout      (sout_l),
    .sout_valid(sout_valid_l),
    .sout_ready(sout_ready),
    .sout_first(sout_first_l),
    .sout_last (sout_last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check one serial bit of the MSB-first instance, then step to the next negedge.
  task automatic expect_bit(input string tag, input logic b, input logic f, input logic l);
    check_val({tag, "_valid"}, 32'(sout_valid), 32'd1);
    check_val({tag, "_sout"},  32'(sout),       32'(b));
    check_val({tag, "_first"}, 32'(sout_first), 32'(f));
    check_val({tag, "_last"},  32'(sout_last),  32'(l));
    @(negedge clk);
  endtask

  logic [11:0] exp_stream;
  logic [11:0] exp_rdy;
  logic [3:0]  words [3];
  logic [3:0]  w;
  int          idx;
  logic        acc;

  initial begin
    rst        = 1'b1;
    a          = 4'd2;
    a_valid    = 1'b1;
    a_l        = 4'd2;
    a_valid_l  = 1'b1;
    sout_ready = 1'b1;

    // Reset with a valid word present: nothing may be taken.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(sout_valid), 32'd0);
    check_val("rst_ready", 32'(a_ready),    32'd1);
    check_val("rst_sout",  32'(sout),       32'd0);
    check_val("rst_first", 32'(sout_first), 32'd0);
    check_val("rst_last",  32'(sout_last),  32'd0);
    check_val("rst_lsb_valid", 32'(sout_valid_l), 32'd0);
    rst       = 1'b0;
    a_valid   = 1'b0;
    a_valid_l = 1'b0;
    @(negedge clk);
    check_val("post_rst_valid", 32'(sout_valid), 32'd0);

    // Single MSB-first word 1010.
    a       = 4'b1010;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    expect_bit("w1010_b0", 1'b1, 1'b1, 1'b0);
    expect_bit("w1010_b1", 1'b0, 1'b0, 1'b0);
    expect_bit("w1010_b2", 1'b1, 1'b0, 1'b0);
    expect_bit("w1010_b3", 1'b0, 1'b0, 1'b1);
    check_val("w1010_done", 32'(sout_valid), 32'd0);

    // Back-to-back words 5, 6, 7 with a_valid and sout_ready held high.
    words[0]   = 4'd5;
    words[1]   = 4'd6;
    words[2]   = 4'd7;
    exp_stream = 12'b0101_0110_0111;
    exp_rdy    = 12'b1111_0001_0001;
    idx        = 0;
    a          = words[0];
    a_valid    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      acc = a_valid & a_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx == 3) a_valid = 1'b0;
        else a = words[idx];
      end
      check_val("b2b_valid", 32'(sout_valid), 32'd1);
      check_val("b2b_sout",  32'(sout),       32'(exp_stream[11-i]));
      check_val("b2b_ready", 32'(a_ready),    32'(exp_rdy[i]));
      check_val("b2b_first", 32'(sout_first), 32'((i % 4) == 0));
      check_val("b2b_last",  32'(sout_last),  32'((i % 4) == 3));
    end
    @(negedge clk);
    check_val("b2b_done", 32'(sout_valid), 32'd0);
    check_val("b2b_words", 32'(idx), 32'd3);

    // Backpressure during bit 2 of word 1001.
    a       = 4'd9;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    expect_bit("bp_b0", 1'b1, 1'b1, 1'b0);
    sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_bit("bp_stall", 1'b0, 1'b0, 1'b0);
    end
    check_val("bp_held_sout", 32'(sout), 32'd0);
    sout_ready = 1'b1;
    expect_bit("bp_b1", 1'b0, 1'b0, 1'b0);
    expect_bit("bp_b2", 1'b0, 1'b0, 1'b0);
    expect_bit("bp_b3", 1'b1, 1'b0, 1'b1);
    check_val("bp_done", 32'(sout_valid), 32'd0);

    // Reset during bit 3 of word 8 while word 9 sits in the hold buffer.
    a       = 4'd8;
    a_valid = 1'b1;
    @(negedge clk);
    a = 4'd9;
    expect_bit("mr_b0", 1'b1, 1'b1, 1'b0);
    a_valid = 1'b0;
    check_val("mr_hold_ready", 32'(a_ready), 32'd0);
    expect_bit("mr_b1", 1'b0, 1'b0, 1'b0);
    check_val("mr_b2_valid", 32'(sout_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mr_valid", 32'(sout_valid), 32'd0);
    check_val("mr_ready", 32'(a_ready),    32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("mr_quiet", 32'(sout_valid), 32'd0);
    end
    a       = 4'd3;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    expect_bit("mr3_b0", 1'b0, 1'b1, 1'b0);
    expect_bit("mr3_b1", 1'b0, 1'b0, 1'b0);
    expect_bit("mr3_b2", 1'b1, 1'b0, 1'b0);
    expect_bit("mr3_b3", 1'b1, 1'b0, 1'b1);
    check_val("mr3_done", 32'(sout_valid), 32'd0);

    // LSB-first instance with word 0111.
    a_l       = 4'b0111;
    a_valid_l = 1'b1;
    @(negedge clk);
    a_valid_l = 1'b0;
    w = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      check_val("lsb_valid", 32'(sout_valid_l), 32'd1);
      check_val("lsb_sout",  32'(sout_l),       32'(w[i]));
      check_val("lsb_first", 32'(sout_first_l), 32'(i == 0));
      check_val("lsb_last",  32'(sout_last_l),  32'(i == 3));
      @(negedge clk);
    end
    check_val("lsb_done", 32'(sout_valid_l), 32'd0);
    check_val("lsb_ready", 32'(a_ready_l), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
